// File: rtl/cim_pkg.sv
// Shared types and constants for the CIM macro sequencer.
package cim_pkg;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 256;
  localparam int ADDR_W = 8;
  localparam int LANES  = 4;
  localparam int ABITS  = 8;
  localparam int NOREG  = 16;
  localparam int IDX_W  = 4;
  localparam int CNT_W  = $clog2(ABITS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    COMP = 2'd1,
    WB   = 2'd2
  } state_t;

  typedef logic [DATA_W-1:0] word_t;

  // Pull lane `lane` out of a packed row and sign-extend it to a full word.
  function automatic word_t lane_sext(input word_t row, input int lane);
    logic [ABITS-1:0] v;
    v = row[lane*ABITS +: ABITS];
    return {{(DATA_W-ABITS){v[ABITS-1]}}, v};
  endfunction

endpackage

// File: rtl/cim_bitserial_lane_sum.sv
// Sum of the sign-extended weights whose activation bit is set in the
// current bit-plane.
module cim_bitserial_lane_sum
  import cim_pkg::*;
(
  input  logic [DATA_W-1:0] weights,
  input  logic [LANES-1:0]  act_bits,
  output logic [DATA_W-1:0] part
);

  // Add the selected lanes for this bit-plane.
  always_comb begin
    // NOTE: a combinational block assigns every output a default before any
    // condition; otherwise a path that skips the assignment infers a latch.
    part = '0;
    for (int i = 0; i < LANES; i++) begin
      if (act_bits[i]) begin
        part = part + lane_sext(weights, i);
      end
    end
  end

endmodule

// File: rtl/cim_macro_ctrl.sv
// Compute-in-memory sequencer: weight array, bit-serial dot product engine
// and output-register bank, fed by the core's CIM strobes.
module cim_macro_ctrl
  import cim_pkg::*;
(
  input  logic              CLK,
  input  logic              RES,
  input  logic              web,
  input  logic              cimeb,
  input  logic              partial_sum_eb,
  input  logic              reset_output_reg,
  input  logic [IDX_W-1:0]  output_reg,
  input  logic [31:0]       address,
  input  logic [31:0]       input_data,
  output logic [31:0]       mem_output,
  output logic [31:0]       cim_output,
  output logic              cim_busy
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  word_t              acc_q;
  word_t              acc_nxt;
  word_t              wts_q;
  word_t              acts_q;
  logic [IDX_W-1:0]   idx_q;
  logic               psum_q;      // 1: overwrite target, 0: accumulate into it
  logic [LANES-1:0]   act_bits;
  word_t              part;
  word_t              wb_val;
  logic               last_bit;
  logic               start;
  logic               wr_en;
  logic               rd_en;
  logic               wb_we;
  logic [ADDR_W-1:0]  row;

  word_t              w_mem  [DEPTH];
  word_t              oreg_q [NOREG];

  // Rows beyond DEPTH alias onto the low rows; the upper bits are dropped.
  assign row = address[ADDR_W-1:0];
  logic unused_addr_hi;
  assign unused_addr_hi = ^address[31:ADDR_W];

  // State register.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (RES) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: IDLE -> COMP for ABITS cycles -> one WB cycle -> IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (!cimeb) state_d = COMP;
      COMP:    if (last_bit) state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output/strobe decode from the current state; commands only act in IDLE.
  always_comb begin
    cim_busy = (state_q == COMP) || (state_q == WB);
    start    = (state_q == IDLE) && !cimeb;
    rd_en    = (state_q == IDLE) && cimeb;
    wr_en    = rd_en && !web && !RES;
    wb_we    = (state_q == WB) && !reset_output_reg;
  end

  assign last_bit = (cnt_q == CNT_W'(ABITS - 1));

  // Pick bit `cnt_q` of every activation lane as the current bit-plane.
  always_comb begin
    act_bits = '0;
    for (int i = 0; i < LANES; i++) begin
      act_bits[i] = acts_q[i*ABITS + int'(cnt_q)];
    end
  end

  cim_bitserial_lane_sum u_lane_sum (
    .weights  (wts_q),
    .act_bits (act_bits),
    .part     (part)
  );

  // The activation sign bit carries negative weight, so its plane subtracts.
  assign acc_nxt = last_bit ? acc_q - (part << cnt_q) : acc_q + (part << cnt_q);
  assign wb_val  = psum_q ? acc_q : oreg_q[idx_q] + acc_q;

  // Weight array with a registered read that captures the row at compute start.
  always_ff @(posedge CLK) begin
    // NOTE: the weight RAM and its read register carry no reset so they map
    // onto a plain memory macro; weights survive RES by design.
    if (wr_en) w_mem[row] <= input_data;
    if (start) wts_q <= w_mem[row];
  end

  // Compute datapath: latch the operands at start, then shift-accumulate.
  always_ff @(posedge CLK) begin
    if (RES) begin
      cnt_q  <= '0;
      acc_q  <= '0;
      acts_q <= '0;
      idx_q  <= '0;
      psum_q <= 1'b1;
    end else if (start) begin
      cnt_q  <= '0;
      acc_q  <= '0;
      acts_q <= input_data;
      idx_q  <= output_reg;
      psum_q <= partial_sum_eb;
    end else if (state_q == COMP) begin
      acc_q <= acc_nxt;
      cnt_q <= last_bit ? '0 : cnt_q + 1'b1;
    end
  end

  // Weight readback, with write-through on a weight write; holds while busy.
  always_ff @(posedge CLK) begin
    if (RES)        mem_output <= '0;
    else if (rd_en) mem_output <= web ? w_mem[row] : input_data;
  end

  // Output-register bank; a bank clear beats a coincident writeback.
  always_ff @(posedge CLK) begin
    if (RES || reset_output_reg) begin
      for (int i = 0; i < NOREG; i++) oreg_q[i] <= '0;
    end else if (wb_we) begin
      oreg_q[idx_q] <= wb_val;
    end
  end

  // Selected output register, bypassing a same-cycle writeback to it.
  always_ff @(posedge CLK) begin
    if (RES)                               cim_output <= '0;
    else if (wb_we && idx_q == output_reg) cim_output <= wb_val;
    else                                   cim_output <= oreg_q[output_reg];
  end

endmodule

// File: tb/tb_cim_macro_ctrl.sv
// Self-checking bench for cim_macro_ctrl against a transaction-level model.
module tb_cim_macro_ctrl;

  localparam int BUSY_CYC = 9;   // COMP (8 bit-planes) + WB

  logic        CLK = 1'b0;
  logic        RES;
  logic        web;
  logic        cimeb;
  logic        partial_sum_eb;
  logic        reset_output_reg;
  logic [3:0]  output_reg;
  logic [31:0] address;
  logic [31:0] input_data;
  logic [31:0] mem_output;
  logic [31:0] cim_output;
  logic        cim_busy;

  cim_macro_ctrl dut (
    .CLK              (CLK),
    .RES              (RES),
    .web              (web),
    .cimeb            (cimeb),
    .partial_sum_eb   (partial_sum_eb),
    .reset_output_reg (reset_output_reg),
    .output_reg       (output_reg),
    .address          (address),
    .input_data       (input_data),
    .mem_output       (mem_output),
    .cim_output       (cim_output),
    .cim_busy         (cim_busy)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the result of a compute is the full signed dot product,
  // delivered after a fixed busy window.
  logic [31:0] m_w    [256];
  logic [31:0] m_oreg [16];
  int          m_busy;
  logic [31:0] m_res;
  logic [3:0]  m_idx;
  logic        m_over;
  logic [31:0] m_mem;
  logic [31:0] m_cim;

  function automatic logic [31:0] dot(input logic [31:0] w, input logic [31:0] a);
    int s;
    byte wb, ab;
    s = 0;
    for (int i = 0; i < 4; i++) begin
      wb = w[i*8 +: 8];
      ab = a[i*8 +: 8];
      s += int'(wb) * int'(ab);
    end
    return s;
  endfunction

  task automatic model_edge();
    logic [31:0] nxt_cim;
    logic [7:0]  r;
    r = address[7:0];
    if (RES) begin
      m_busy = 0;
      m_mem  = '0;
      m_cim  = '0;
      for (int i = 0; i < 16; i++) m_oreg[i] = '0;
    end else begin
      nxt_cim = m_oreg[output_reg];
      if (m_busy == 1 && !reset_output_reg) begin
        m_oreg[m_idx] = m_over ? m_res : m_oreg[m_idx] + m_res;
        if (m_idx == output_reg) nxt_cim = m_oreg[m_idx];
      end
      if (reset_output_reg) for (int i = 0; i < 16; i++) m_oreg[i] = '0;
      if (m_busy > 0) begin
        m_busy--;
      end else if (!cimeb) begin
        m_res  = dot(m_w[r], input_data);
        m_idx  = output_reg;
        m_over = partial_sum_eb;
        m_busy = BUSY_CYC;
      end else if (!web) begin
        m_w[r] = input_data;
        m_mem  = input_data;
      end else begin
        m_mem = m_w[r];
      end
      m_cim = nxt_cim;
    end
  endtask

  task automatic cycle();
    @(posedge CLK);
    model_edge();
    #1;
    check("busy", {31'b0, cim_busy}, {31'b0, (m_busy != 0)});
    check("mem_output", mem_output, m_mem);
    check("cim_output", cim_output, m_cim);
  endtask

  task automatic idle();
    web = 1'b1; cimeb = 1'b1; partial_sum_eb = 1'b1; reset_output_reg = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr(input logic [7:0] r);
    return ($urandom() & 32'hFFFF_FF00) | {24'b0, r};
  endfunction

  task automatic do_write(input logic [7:0] r, input logic [31:0] d);
    web = 1'b0; address = rand_addr(r); input_data = d;
    cycle(); idle();
  endtask

  task automatic do_read(input logic [7:0] r);
    address = rand_addr(r);
    cycle();
  endtask

  task automatic do_start(input logic [7:0] r, input logic [31:0] acts,
                          input logic [3:0] idx, input logic over);
    cimeb = 1'b0; address = rand_addr(r); input_data = acts;
    output_reg = idx; partial_sum_eb = over;
    cycle(); idle();
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 20 && m_busy != 0; k++) cycle();
  endtask

  int n;

  initial begin
    idle();
    RES = 1'b1; output_reg = '0; address = '0; input_data = '0;
    m_busy = 0; m_mem = '0; m_cim = '0; m_res = '0; m_idx = '0; m_over = 1'b1;
    for (int i = 0; i < 16; i++) m_oreg[i] = '0;
    for (int i = 0; i < 3; i++) cycle();
    RES = 1'b0;

    // Give every weight row a defined value.
    for (int i = 0; i < 256; i++) do_write(8'(i), $urandom());

    // Write-through and readback.
    do_write(8'd3, 32'h04FF_0201);
    check("t1_write_through", mem_output, 32'h04FF_0201);
    do_write(8'd4, 32'h1111_2222);
    do_read(8'd3);
    check("t1_read", mem_output, 32'h04FF_0201);

    // Weights {1,2,-1,4}, activations all 1, overwrite into OREG[5].
    do_start(8'd3, 32'h0101_0101, 4'd5, 1'b1);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      if (cim_busy) n++;
      cycle();
    end
    check("t2_busy_cycles", n, BUSY_CYC);
    check("t2_result", cim_output, 32'd6);

    // Accumulate mode, then negative activations.
    do_start(8'd3, 32'h0101_0101, 4'd5, 1'b0);
    wait_idle(); cycle();
    check("t3_accumulate", cim_output, 32'd12);
    do_start(8'd3, 32'h8080_8080, 4'd5, 1'b0);
    wait_idle(); cycle();
    check("t3_negative", cim_output, 32'(-756));

    // Commands while busy are ignored; a clear in WB drops the writeback.
    do_start(8'd3, 32'h0101_0101, 4'd5, 1'b0);
    for (int k = 0; k < 8; k++) begin
      web = 1'b0; cimeb = 1'b0; address = rand_addr(8'd3); input_data = 32'hDEAD_BEEF;
      cycle();
    end
    idle();
    check("t4_busy_in_wb", {31'b0, cim_busy}, 32'd1);
    reset_output_reg = 1'b1;
    cycle();
    reset_output_reg = 1'b0;
    cycle();
    check("t4_clear_wins", cim_output, 32'd0);
    check("t4_idle_after", {31'b0, cim_busy}, 32'd0);
    do_read(8'd3);
    check("t4_weights_kept", mem_output, 32'h04FF_0201);

    // Synchronous reset in the middle of a compute.
    do_start(8'd3, 32'h0101_0101, 4'd5, 1'b1);
    for (int k = 0; k < 4; k++) cycle();
    RES = 1'b1;
    cycle();
    RES = 1'b0;
    check("t5_busy", {31'b0, cim_busy}, 32'd0);
    check("t5_mem", mem_output, 32'd0);
    check("t5_cim", cim_output, 32'd0);
    cycle(); cycle();
    check("t5_no_writeback", cim_output, 32'd0);
    do_read(8'd3);
    check("t5_weights_kept", mem_output, 32'h04FF_0201);

    // Randomized traffic, including commands while busy and clears.
    for (int it = 0; it < 3000; it++) begin
      int r;
      idle();
      r = $urandom_range(0, 99);
      output_reg = 4'($urandom());
      address = $urandom();
      input_data = $urandom();
      partial_sum_eb = 1'($urandom());
      RES = (r < 2);
      if (r >= 2 && r < 6) reset_output_reg = 1'b1;
      else if (r < 28) web = 1'b0;
      else if (r < 45) cimeb = 1'b0;
      else if (r < 60) begin web = 1'b0; cimeb = 1'b0; end
      cycle();
    end
    RES = 1'b0; idle();
    wait_idle();

    // Long accumulation of the largest positive products.
    reset_output_reg = 1'b1; cycle(); idle();
    do_write(8'd7, 32'h7F7F_7F7F);
    for (int k = 0; k < 1500; k++) begin
      do_start(8'd7, 32'h7F7F_7F7F, 4'd9, 1'b0);
      wait_idle();
    end
    cycle();
    check("t6_accumulated", cim_output, 32'(1500 * 64516));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
